mul_flag_sched: RTL and testbench

//  Execute-stage scheduler for the iterative multiplier. It owns the shared NZCV flag register and sequences MUL/MULS.
//  It launches the multiplier and stalls F/D/E while the multiplier runs.
//  It arbitrates flag-register writes between the single-cycle ALU path and the multiplier's N/Z writeback.
//  Its Flags output feeds condition_check in the controller.

---
 rtl/mul_flag_sched.sv | 115 +++++++++++
 tb/tb_mul_flag_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_flag_sched.sv
// Execute-stage scheduler for the iterative multiplier: owns the NZCV flag
// register, launches MUL/MULS, stalls F/D/E and arbitrates flag writes.
module mul_flag_sched #(
  parameter int unsigned MUL_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MulStartE,
  input  logic       MulSE,
  input  logic       CondExE,
  input  logic [1:0] ALUFlagWriteE,
  input  logic [3:0] ALUFlagsE,
  input  logic       MulN,
  input  logic       MulZ,
  output logic       MulGo,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic [3:0] Flags,
  output logic       MulBusy
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_s_q, mul_s_d;
  logic [3:0]       flags_q, flags_d;

  logic launch_c;
  logic alu_ok_c;
  logic go_c;
  logic stall_c;

  assign launch_c = MulStartE & CondExE;

  // State, busy counter, S-bit latch and NZCV register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mul_s_q <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_s_q <= mul_s_d;
      flags_q <= flags_d;
    end
  end

  // Next-state, launch/stall decode and flag-write arbitration.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_s_d  = mul_s_q;
    flags_d  = flags_q;
    go_c     = 1'b0;
    stall_c  = 1'b0;
    alu_ok_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // ALU writes only when Execute holds a non-MUL instruction.
        alu_ok_c = CondExE & ~MulStartE;
        if (alu_ok_c && ALUFlagWriteE[1]) begin
          flags_d[3:2] = ALUFlagsE[3:2];
        end
        if (alu_ok_c && ALUFlagWriteE[0]) begin
          flags_d[1:0] = ALUFlagsE[1:0];
        end
        if (launch_c) begin
          go_c    = 1'b1;
          stall_c = 1'b1;
          cnt_d   = CNT_LOAD;
          mul_s_d = MulSE;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        // MUL writeback of N/Z; C and V hold. Launches here are ignored.
        if (mul_s_q) begin
          flags_d[3:2] = {MulN, MulZ};
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign MulGo   = go_c & reset;
  assign StallF  = stall_c & reset;
  assign StallD  = stall_c & reset;
  assign StallE  = stall_c & reset;
  assign Flags   = flags_q;
  assign MulBusy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_flag_sched.sv
// Scoreboard bench for mul_flag_sched: expected flag values are queued when
// stimulus is applied and compared when the register is due to show them.
module tb_mul_flag_sched;

  localparam int unsigned MC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       MulStartE = 1'b0;
  logic       MulSE = 1'b0;
  logic       CondExE = 1'b0;
  logic [1:0] ALUFlagWriteE = 2'b00;
  logic [3:0] ALUFlagsE = 4'b0000;
  logic       MulN = 1'b0;
  logic       MulZ = 1'b0;
  logic       MulGo, StallF, StallD, StallE, MulBusy;
  logic [3:0] Flags;

  logic [4:0] ctl;
  logic [3:0] sb_q[$];
  logic [3:0] model_flags;
  logic [3:0] exp_f;
  int checks = 0;
  int errors = 0;

  mul_flag_sched #(.MUL_CYCLES(MC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .MulStartE(MulStartE), .MulSE(MulSE),
    .CondExE(CondExE), .ALUFlagWriteE(ALUFlagWriteE), .ALUFlagsE(ALUFlagsE),
    .MulN(MulN), .MulZ(MulZ), .MulGo(MulGo), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .Flags(Flags), .MulBusy(MulBusy)
  );

  always #5 clk = ~clk;

  assign ctl = {MulGo, StallF, StallD, StallE, MulBusy};

  // Expected {MulGo,StallF,StallD,StallE,MulBusy} k cycles after a launch.
  function automatic logic [4:0] mul_ctl(input int k);
    if (k == 0) return 5'b11110;
    if (k <= int'(MC)) return 5'b01111;
    if (k == int'(MC) + 1) return 5'b00001;
    return 5'b00000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MulStartE = 1'b0; MulSE = 1'b0; CondExE = 1'b0;
    ALUFlagWriteE = 2'b00; ALUFlagsE = 4'b0000; MulN = 1'b0; MulZ = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; MulStartE = 1'b1; CondExE = 1'b1;
    #3;
    checks++;
    if (ctl !== 5'b00000) begin errors++; $display("FAIL reset_ctl: got %b expected 00000", ctl); end
    checks++;
    if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", Flags); end
    tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== 5'b00000) begin errors++; $display("FAIL reset_release_ctl: got %b expected 00000", ctl); end
    tick();
    #1;
    checks++;
    if (ctl !== 5'b00000) begin errors++; $display("FAIL reset_after_ctl: got %b expected 00000", ctl); end
    model_flags = 4'b0000;
  endtask

  task automatic test_alu_write();
    logic       t_cond[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] t_fw[6]   = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
    logic [3:0] t_af[6]   = '{4'b1010, 4'b1010, 4'b0101, 4'b1001, 4'b1111, 4'b0011};
    logic [3:0] t_exp[6]  = '{4'b0000, 4'b1010, 4'b0110, 4'b0101, 4'b0101, 4'b0011};
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i > 0) begin
        exp_f = sb_q.pop_front();
        model_flags = exp_f;
        checks++;
        if (Flags !== exp_f) begin errors++; $display("FAIL alu_write[%0d]: got %b expected %b", i-1, Flags, exp_f); end
      end
      idle_inputs();
      if (i < 6) begin
        CondExE = t_cond[i]; ALUFlagWriteE = t_fw[i]; ALUFlagsE = t_af[i];
        sb_q.push_back(t_exp[i]);
      end
      #1;
      checks++;
      if (ctl !== 5'b00000) begin errors++; $display("FAIL alu_ctl[%0d]: got %b expected 00000", i, ctl); end
    end
  endtask

  task automatic test_muls();
    for (int k = 0; k <= int'(MC) + 2; k++) begin
      tick();
      idle_inputs();
      MulStartE = (k <= int'(MC) + 1); MulSE = 1'b1; CondExE = 1'b1; MulN = 1'b0; MulZ = 1'b1;
      if (k == 0) sb_q.push_back({2'b01, model_flags[1:0]});
      if (k == int'(MC) + 2) begin
        MulStartE = 1'b0;
        exp_f = sb_q.pop_front();
        model_flags = exp_f;
      end
      #1;
      checks++;
      if (ctl !== mul_ctl(k)) begin errors++; $display("FAIL muls_ctl[%0d]: got %b expected %b", k, ctl, mul_ctl(k)); end
      checks++;
      if (Flags !== model_flags) begin errors++; $display("FAIL muls_flags[%0d]: got %b expected %b", k, Flags, model_flags); end
    end
  endtask

  task automatic test_mul_nos();
    for (int k = 0; k <= int'(MC) + 2; k++) begin
      tick();
      idle_inputs();
      MulStartE = (k <= int'(MC) + 1); MulSE = 1'b0; CondExE = 1'b1; MulN = 1'b1; MulZ = 1'b0;
      if (k == 0) sb_q.push_back(model_flags);
      if (k == int'(MC) + 2) model_flags = sb_q.pop_front();
      #1;
      checks++;
      if (ctl !== mul_ctl(k)) begin errors++; $display("FAIL mul_nos_ctl[%0d]: got %b expected %b", k, ctl, mul_ctl(k)); end
      checks++;
      if (Flags !== 4'b0111) begin errors++; $display("FAIL mul_nos_flags[%0d]: got %b expected 0111", k, Flags); end
    end
  endtask

  task automatic test_cond_fail();
    for (int k = 0; k < 4; k++) begin
      tick();
      idle_inputs();
      if (k < 3) begin
        MulStartE = 1'b1; MulSE = 1'b1; CondExE = 1'b0; MulN = 1'b1; MulZ = 1'b1;
        ALUFlagWriteE = 2'b11; ALUFlagsE = 4'b1111;
      end
      #1;
      checks++;
      if (ctl !== 5'b00000) begin errors++; $display("FAIL cond_fail_ctl[%0d]: got %b expected 00000", k, ctl); end
      checks++;
      if (Flags !== 4'b0111) begin errors++; $display("FAIL cond_fail_flags[%0d]: got %b expected 0111", k, Flags); end
    end
  endtask

  task automatic test_alu_during_busy();
    for (int k = 0; k <= int'(MC) + 2; k++) begin
      tick();
      idle_inputs();
      CondExE = 1'b1; MulN = 1'b1; MulZ = 1'b0; MulSE = 1'b1;
      if (k == 0) begin
        MulStartE = 1'b1;
        sb_q.push_back({2'b10, model_flags[1:0]});
      end else if (k <= int'(MC) + 1) begin
        ALUFlagWriteE = 2'b11; ALUFlagsE = 4'b0000;
      end else begin
        model_flags = sb_q.pop_front();
      end
      #1;
      checks++;
      if (ctl !== mul_ctl(k)) begin errors++; $display("FAIL busy_alu_ctl[%0d]: got %b expected %b", k, ctl, mul_ctl(k)); end
      checks++;
      if (Flags !== model_flags) begin errors++; $display("FAIL busy_alu_flags[%0d]: got %b expected %b", k, Flags, model_flags); end
    end
    checks++;
    if (Flags !== 4'b1011) begin errors++; $display("FAIL busy_alu_final: got %b expected 1011", Flags); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int w;
    w = int'(MC) + 2;
    for (int k = 0; k <= 2 * w; k++) begin
      tick();
      idle_inputs();
      MulStartE = (k < 2 * w); MulSE = 1'b1; CondExE = 1'b1;
      MulN = (k >= w); MulZ = (k >= w);
      if (k == w || k == 2 * w) model_flags = sb_q.pop_front();
      if (k == 0) sb_q.push_back({2'b00, model_flags[1:0]});
      if (k == w) sb_q.push_back({2'b11, model_flags[1:0]});
      #1;
      e = (k < w) ? mul_ctl(k) : mul_ctl(k - w);
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL b2b_ctl[%0d]: got %b expected %b", k, ctl, e); end
      checks++;
      if (Flags !== model_flags) begin errors++; $display("FAIL b2b_flags[%0d]: got %b expected %b", k, Flags, model_flags); end
    end
    checks++;
    if (Flags !== 4'b1111) begin errors++; $display("FAIL b2b_final: got %b expected 1111", Flags); end
  endtask

  task automatic test_reset_mid_busy();
    tick();
    idle_inputs();
    MulStartE = 1'b1; MulSE = 1'b1; CondExE = 1'b1; MulN = 1'b0; MulZ = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b11110) begin errors++; $display("FAIL rst_busy_launch: got %b expected 11110", ctl); end
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b00000) begin errors++; $display("FAIL rst_busy_ctl: got %b expected 00000", ctl); end
    checks++;
    if (Flags !== 4'b0000) begin errors++; $display("FAIL rst_busy_flags: got %b expected 0000", Flags); end
    tick();
    MulStartE = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < int'(MC) + 4; k++) begin
      tick();
      checks++;
      if (ctl !== 5'b00000 || Flags !== 4'b0000) begin
        errors++;
        $display("FAIL rst_release[%0d]: got ctl=%b flags=%b expected 00000/0000", k, ctl, Flags);
      end
    end
  endtask

  initial begin
    model_flags = 4'b0000;
    test_reset();
    test_alu_write();
    test_muls();
    test_mul_nos();
    test_cond_fail();
    test_alu_during_busy();
    test_back_to_back();
    test_reset_mid_busy();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
